// File: rtl/fetch_ctrl.sv
// fetch_ctrl: owns the architectural PC, sequences imem req/gnt/rvalid fetches and holds the word for decode.
// Optional build macro FETCH_PERF_EN adds perf_fetched / perf_redirect event counters.
module fetch_ctrl #(
    parameter int             PCW      = 32,
    parameter logic [PCW-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic           clk,
    input  logic           rst,
    output logic           imem_req,
    output logic [PCW-1:0] imem_addr,
    input  logic           imem_gnt,
    input  logic           imem_rvalid,
    input  logic [31:0]    imem_rdata,
    output logic           if_valid,
    output logic [31:0]    if_instr,
    output logic [PCW-1:0] if_pc,
    input  logic           id_ready,
    input  logic           redir_valid,
    input  logic [1:0]     redir_type,
    input  logic [PCW-1:0] redir_pc,
    input  logic [31:0]    redir_imm,
    input  logic           redir_zero
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]    perf_fetched,
    output logic [31:0]    perf_redirect
`endif
);

    typedef enum logic [1:0] {
        S_ISSUE = 2'b00,
        S_WAIT  = 2'b01,
        S_HOLD  = 2'b10
    } state_t;

    state_t         state;
    logic [PCW-1:0] pc;
    logic           kill;
    logic [PCW-1:0] target;
    logic           unused_imm_bits;

    function automatic logic [PCW-1:0] redirect_target(
        input logic [1:0]     rtype,
        input logic [PCW-1:0] rpc,
        input logic [31:0]    imm,
        input logic           zero
    );
        logic [PCW-1:0]        seq_pc;
        logic signed [PCW-1:0] br_off;
        seq_pc = rpc + PCW'(4);
        br_off = {{(PCW-16){imm[13]}}, imm[13:0], 2'b00};
        if (rtype == 2'b10)
            return {rpc[PCW-1:PCW-4], imm[25:0], 2'b00};
        else if (rtype == 2'b01 && zero)
            return seq_pc + br_off;
        else
            return seq_pc;
    endfunction

    assign target          = redirect_target(redir_type, redir_pc, redir_imm, redir_zero);
    assign imem_addr       = pc;
    assign unused_imm_bits = ^redir_imm[31:26];

    // ISSUE always spends one cycle with imem_req low before raising it, so a
    // redirect or a fresh entry never changes imem_addr under an asserted request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_ISSUE;
            pc       <= RESET_PC;
            kill     <= 1'b0;
            imem_req <= 1'b0;
            if_valid <= 1'b0;
            if_instr <= '0;
            if_pc    <= '0;
        end else begin
            case (state)
                S_ISSUE: begin
                    if (redir_valid) begin
                        pc       <= target;
                        imem_req <= 1'b0;
                        if (imem_req && imem_gnt) begin
                            state <= S_WAIT;
                            kill  <= 1'b1;
                        end
                    end else if (imem_req && imem_gnt) begin
                        imem_req <= 1'b0;
                        state    <= S_WAIT;
                    end else begin
                        imem_req <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (redir_valid) begin
                        pc <= target;
                        if (imem_rvalid) begin
                            kill  <= 1'b0;
                            state <= S_ISSUE;
                        end else begin
                            kill <= 1'b1;
                        end
                    end else if (imem_rvalid) begin
                        if (kill) begin
                            kill  <= 1'b0;
                            state <= S_ISSUE;
                        end else begin
                            if_instr <= imem_rdata;
                            if_pc    <= pc;
                            if_valid <= 1'b1;
                            pc       <= pc + PCW'(4);
                            state    <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (redir_valid) begin
                        pc       <= target;
                        if_valid <= 1'b0;
                        state    <= S_ISSUE;
                    end else if (id_ready) begin
                        if_valid <= 1'b0;
                        state    <= S_ISSUE;
                    end
                end
                default: begin
                    state    <= S_ISSUE;
                    imem_req <= 1'b0;
                    if_valid <= 1'b0;
                    kill     <= 1'b0;
                end
            endcase
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetched  <= '0;
            perf_redirect <= '0;
        end else begin
            if (if_valid && id_ready && !redir_valid)
                perf_fetched <= perf_fetched + 32'd1;
            if (redir_valid && (redir_type == 2'b10 || (redir_type == 2'b01 && redir_zero)))
                perf_redirect <= perf_redirect + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios plus randomized imem/decode/redirect traffic
// checked against a transaction-level model of the fetch stream.
`timescale 1ns/1ps
module tb_fetch_ctrl;
    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        id_ready;
    logic        redir_valid;
    logic [1:0]  redir_type;
    logic [31:0] redir_pc;
    logic [31:0] redir_imm;
    logic        redir_zero;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_redirect;
`endif

    always #5 clk = ~clk;

    fetch_ctrl #(.PCW(32), .RESET_PC(RST_PC)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .id_ready(id_ready),
        .redir_valid(redir_valid), .redir_type(redir_type), .redir_pc(redir_pc),
        .redir_imm(redir_imm), .redir_zero(redir_zero)
`ifdef FETCH_PERF_EN
        , .perf_fetched(perf_fetched), .perf_redirect(perf_redirect)
`endif
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: timed out waiting for DUT (t=%0t)", name, $time);
    endtask

    // Instruction memory contents: a fixed scramble of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    function automatic logic [31:0] model_target(input logic [1:0] t, input logic [31:0] pc,
                                                 input logic [31:0] imm, input logic z);
        int off;
        if (t == 2'b01 && z) begin
            off = int'(imm[13:0]);
            if (off >= 8192) off = off - 16384;
            return pc + 32'd4 + 32'(off * 4);
        end
        if (t == 2'b10)
            return (pc & 32'hF000_0000) | ((imm & 32'h03FF_FFFF) << 2);
        return pc + 32'd4;
    endfunction

    // ---------------- model + compare process ----------------
    logic [31:0] exp_pc = RST_PC;
    bit started = 0, prev_rst = 0, prev_hold = 0, prev_clear = 0;
    bit prev_req_hold = 0, prev_req_gnt = 0, chk_req_up = 0;
    int cyc = 0, xfer_cnt = 0, last_xfer_cyc = 0, prev_xfer_cyc = 0;
    logic [31:0] last_xfer_pc = '0;
    logic [31:0] m_fetched = '0, m_redir = '0;

    always @(negedge clk) begin
        cyc++;
        if (started) begin
            if (prev_rst) begin
                check32("rst_if_valid", {31'b0, if_valid}, 32'd0);
                check32("rst_imem_req", {31'b0, imem_req}, 32'd0);
                check32("rst_if_pc", if_pc, 32'd0);
                check32("rst_if_instr", if_instr, 32'd0);
                check32("rst_imem_addr", imem_addr, RST_PC);
            end
            if (chk_req_up) check32("req_after_reset", {31'b0, imem_req}, 32'd1);
            if (imem_req) check32("imem_addr", imem_addr, exp_pc);
            if (if_valid) begin
                check32("if_pc", if_pc, exp_pc);
                check32("if_instr", if_instr, mem_word(exp_pc));
            end
            check32("req_with_valid", {31'b0, imem_req & if_valid}, 32'd0);
            if (prev_hold)     check32("valid_held", {31'b0, if_valid}, 32'd1);
            if (prev_clear)    check32("valid_dropped", {31'b0, if_valid}, 32'd0);
            if (prev_req_hold) check32("req_held", {31'b0, imem_req}, 32'd1);
            if (prev_req_gnt)  check32("req_after_gnt", {31'b0, imem_req}, 32'd0);
`ifdef FETCH_PERF_EN
            check32("perf_fetched", perf_fetched, m_fetched);
            check32("perf_redirect", perf_redirect, m_redir);
`endif
        end
        chk_req_up = prev_rst && !rst && !redir_valid;
        if (rst) begin
            started = 1; prev_rst = 1; exp_pc = RST_PC;
            prev_hold = 0; prev_clear = 0; prev_req_hold = 0; prev_req_gnt = 0;
            m_fetched = '0; m_redir = '0;
        end else if (started) begin
            prev_rst      = 0;
            prev_hold     = if_valid && !id_ready && !redir_valid;
            prev_clear    = if_valid && (id_ready || redir_valid);
            prev_req_hold = imem_req && !imem_gnt && !redir_valid;
            prev_req_gnt  = imem_req && imem_gnt;
            if (if_valid && id_ready && !redir_valid) begin
                xfer_cnt++;
                prev_xfer_cyc = last_xfer_cyc;
                last_xfer_cyc = cyc;
                last_xfer_pc  = if_pc;
                exp_pc        = exp_pc + 32'd4;
                m_fetched     = m_fetched + 32'd1;
            end
            if (redir_valid) begin
                exp_pc = model_target(redir_type, redir_pc, redir_imm, redir_zero);
                if (redir_type == 2'b10 || (redir_type == 2'b01 && redir_zero))
                    m_redir = m_redir + 32'd1;
            end
        end
    end

    // ---------------- stimulus: imem responder, decode, execute ----------------
    bit          pend_valid = 0;
    int          pend_wait = 0;
    logic [31:0] pend_addr = '0, gnt_addr = '0;
    int gnt_pct = 100, ready_pct = 100, redir_pct = 0, lat_min = 1, lat_max = 1, rst_permille = 0;
    int force_ready = -1;
    bit rst_req = 0, inj = 0;
    logic [1:0]  inj_type = '0;
    logic [31:0] inj_pc = '0, inj_imm = '0;
    logic        inj_zero = 1'b0;

    task automatic drive_cycle();
        @(posedge clk);
        #1;
        if (imem_rvalid) pend_valid = 0;
        if (imem_gnt) begin
            pend_valid = 1;
            pend_addr  = gnt_addr;
            pend_wait  = int'($urandom_range(lat_max, lat_min)) - 1;
        end else if (pend_valid && pend_wait > 0) begin
            pend_wait--;
        end
        rst         = rst_req || ($urandom_range(999) < rst_permille);
        imem_rvalid = pend_valid && pend_wait == 0;
        imem_rdata  = imem_rvalid ? mem_word(pend_addr) : $urandom();
        imem_gnt    = !rst && imem_req && !pend_valid && ($urandom_range(99) < gnt_pct);
        gnt_addr    = imem_addr;
        id_ready    = (force_ready >= 0) ? force_ready[0] : ($urandom_range(99) < ready_pct);
        redir_type  = 2'($urandom_range(3));
        redir_pc    = $urandom();
        redir_imm   = $urandom();
        redir_zero  = 1'($urandom_range(1));
        if (inj) begin
            redir_valid = 1'b1;
            redir_type  = inj_type;
            redir_pc    = inj_pc;
            redir_imm   = inj_imm;
            redir_zero  = inj_zero;
            inj         = 0;
        end else begin
            redir_valid = !rst && ($urandom_range(99) < redir_pct);
        end
    endtask

    task automatic wait_xfer(input string name, input logic [31:0] exp);
        int start;
        int n;
        start = xfer_cnt;
        n = 0;
        while (xfer_cnt == start && n < 200) begin
            drive_cycle();
            n++;
        end
        if (xfer_cnt == start) timeout(name);
        else check32(name, last_xfer_pc, exp);
    endtask

    task automatic wait_valid(input string name);
        int n;
        n = 0;
        while (!(if_valid === 1'b1) && n < 200) begin
            drive_cycle();
            n++;
        end
        if (!(if_valid === 1'b1)) timeout(name);
    endtask

    task automatic wait_gnt(input string name);
        int n;
        n = 0;
        while (!imem_gnt && n < 200) begin
            drive_cycle();
            n++;
        end
        if (!imem_gnt) timeout(name);
    endtask

    task automatic redirect_in_hold(input logic [1:0] t, input logic [31:0] pc,
                                    input logic [31:0] imm, input logic z,
                                    input string name, input logic [31:0] exp);
        force_ready = 0;
        wait_valid({name, "_hold"});
        inj = 1; inj_type = t; inj_pc = pc; inj_imm = imm; inj_zero = z;
        force_ready = 1;
        drive_cycle();
        force_ready = -1;
        wait_xfer(name, exp);
    endtask

    initial begin
        rst = 1'b1; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0; id_ready = 1'b0;
        redir_valid = 1'b0; redir_type = '0; redir_pc = '0; redir_imm = '0; redir_zero = 1'b0;
        rst_req = 1;
        repeat (3) drive_cycle();
        rst_req = 0;

        // Back-to-back fetch with single-cycle memory and an always-ready decode.
        wait_xfer("seq0", 32'h0000_0100);
        wait_xfer("seq1", 32'h0000_0104);
        wait_xfer("seq2", 32'h0000_0108);
        check32("cycles_per_instr", 32'(last_xfer_cyc - prev_xfer_cyc), 32'd4);

        // Decode stalls: the held word must stay put and no fetch may start.
        force_ready = 0;
        wait_valid("stall_hold");
        for (int i = 0; i < 5; i++) begin
            check32("stall_if_pc", if_pc, 32'h0000_010C);
            check32("stall_no_req", {31'b0, imem_req}, 32'd0);
            drive_cycle();
        end
        force_ready = 1;
        wait_xfer("stall_release", 32'h0000_010C);
        force_ready = -1;

        redirect_in_hold(2'b01, 32'h0000_0200, 32'h0000_3FFF, 1'b1, "beq_taken", 32'h0000_0200);
        redirect_in_hold(2'b01, 32'h0000_0200, 32'h0000_3FFF, 1'b0, "beq_not_taken", 32'h0000_0204);
        redirect_in_hold(2'b10, 32'h9000_0010, 32'h0000_0040, 1'b0, "jump", 32'h9000_0100);

        // Redirect while a response is outstanding; the stale word must be dropped.
        lat_min = 3; lat_max = 3;
        wait_gnt("wait_redir_gnt");
        inj = 1; inj_type = 2'b10; inj_pc = 32'h0000_1000; inj_imm = 32'h0000_0100; inj_zero = 1'b0;
        drive_cycle();
        wait_xfer("redir_in_wait", 32'h0000_0400);

        // Reset while a response is outstanding; the late response must be ignored.
        wait_gnt("rst_wait_gnt");
        rst_req = 1;
        drive_cycle();
        rst_req = 0;
        wait_xfer("rst_in_wait", RST_PC);

        // Randomized traffic.
        gnt_pct = 60; ready_pct = 70; redir_pct = 8; lat_min = 1; lat_max = 4; rst_permille = 3;
        repeat (4000) drive_cycle();
        rst_permille = 0; redir_pct = 0;
        repeat (20) drive_cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
